// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter and its transmitter:
// FSM state encoding, frame timing defaults and a small index helper.
package uart_pkg;

  localparam int BYTE_W = 8;

  // Bit period of the transmitter in clock cycles.
  localparam int CLKS_PER_BIT = 104;

  // One frame is 10 bit periods; two extra cycles cover the done pulse.
  localparam int FRAME_CYCLES_DEF = 10 * CLKS_PER_BIT + 2;

  typedef enum logic [2:0] {
    FLUSH = 3'd0,
    IDLE  = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    GAP   = 3'd5
  } arb_state_e;

  // Next requester index after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    int nxt;
    nxt = idx + 1;
    if (nxt >= n) begin
      nxt = 0;
    end else begin
      nxt = idx + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester bus plus transmitter strobe/byte/done, shared by producers,
// the arbiter and the transmitter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_start;
  logic [BYTE_W-1:0]         tx_byte;
  logic                      tx_done;

  // Producer/transmitter side of the bus.
  modport master (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, tx_start, tx_byte
  );

  // Arbiter side of the bus.
  modport slave (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, tx_start, tx_byte
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping around the request vector.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  // Scan from the farthest offset back to ptr so the closest request wins.
  always_comb begin
    logic [IW-1:0] idx_s;
    gnt     = {N{1'b0}};
    gnt_idx = {IW{1'b0}};
    gnt_any = 1'b0;
    idx_s   = {IW{1'b0}};
    for (int off = N - 1; off >= 0; off--) begin
      idx_s = IW'((int'(ptr) + off) % N);
      if (req[idx_s]) begin
        gnt        = {N{1'b0}};
        gnt[idx_s] = 1'b1;
        gnt_idx    = idx_s;
        gnt_any    = 1'b1;
      end else begin
        gnt_any = gnt_any;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers. Round-robin
// grant with burst lock, post-reset flush, inter-frame gap and a sticky
// completion watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int MAX_BURST    = 16,
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_tx_arbiter_if.slave           bus,
  output logic                       grant_vld,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(FRAME_CYCLES + 1);
  localparam int GW  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam int BW  = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] CYC_MAX    = {CW{1'b1}};
  localparam logic [GW-1:0] GAP_LAST   = (GAP_CYCLES == 0) ? {GW{1'b0}} : GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_MAX    = {GW{1'b1}};
  localparam logic [BW-1:0] BURST_LIM  = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_MAX  = {BW{1'b1}};

  arb_state_e          state_r;
  arb_state_e          state_nxt_s;
  logic [CW-1:0]       cyc_cnt_r;
  logic [GW-1:0]       gap_cnt_r;
  logic [BW-1:0]       burst_cnt_r;
  logic [IDW-1:0]      rr_ptr_r;
  logic [IDW-1:0]      grant_id_r;
  logic                grant_vld_r;
  logic [BYTE_W-1:0]   tx_byte_r;
  logic                tx_start_r;
  logic                last_flag_r;
  logic                err_timeout_r;
  logic                busy_r;
  logic                tx_done_q_r;
  logic [NUM_REQ-1:0]  req_ready_s;
  logic [NUM_REQ-1:0]  arb_gnt_s;
  logic [IDW-1:0]      arb_idx_s;
  logic                arb_any_s;
  logic                done_rise_s;
  logic                sel_valid_s;
  logic                cyc_end_s;
  logic                gap_end_s;
  logic                burst_ok_s;
  logic                keep_lock_s;
  logic [IDW-1:0]      rr_next_s;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_r),
    .gnt     (arb_gnt_s),
    .gnt_idx (arb_idx_s),
    .gnt_any (arb_any_s)
  );

  // Only the rising edge of tx_done ends a frame, so its 2-cycle pulse counts once.
  assign done_rise_s = bus.tx_done & ~tx_done_q_r;
  assign sel_valid_s = bus.req_valid[grant_id_r];
  assign cyc_end_s   = (cyc_cnt_r >= FRAME_LAST);
  assign gap_end_s   = (gap_cnt_r >= GAP_LAST);
  assign burst_ok_s  = (MAX_BURST == 0) || (burst_cnt_r < BURST_LIM);
  assign keep_lock_s = ~last_flag_r & burst_ok_s;
  assign rr_next_s   = IDW'(wrap_inc(int'(grant_id_r), NUM_REQ));

  assign bus.req_ready = req_ready_s;
  assign bus.tx_start  = tx_start_r;
  assign bus.tx_byte   = tx_byte_r;
  assign grant_vld     = grant_vld_r;
  assign grant_id      = grant_id_r;
  assign busy          = busy_r;
  assign err_timeout   = err_timeout_r;

  // State register; reset restarts the flush so a frame in flight can finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FLUSH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection and the combinational accept strobe.
  always_comb begin
    state_nxt_s = state_r;
    req_ready_s = {NUM_REQ{1'b0}};
    case (state_r)
      FLUSH: begin
        if (cyc_end_s) state_nxt_s = IDLE;
        else           state_nxt_s = FLUSH;
      end
      IDLE: begin
        if (arb_any_s) state_nxt_s = LOAD;
        else           state_nxt_s = IDLE;
      end
      LOAD: begin
        if (sel_valid_s) begin
          req_ready_s[grant_id_r] = 1'b1;
          state_nxt_s             = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (done_rise_s)    state_nxt_s = GAP;
        else if (cyc_end_s) state_nxt_s = GAP;
        else                state_nxt_s = WAIT;
      end
      GAP: begin
        if (gap_end_s && keep_lock_s) state_nxt_s = LOAD;
        else if (gap_end_s)           state_nxt_s = IDLE;
        else                          state_nxt_s = GAP;
      end
      default: begin
        state_nxt_s = FLUSH;
      end
    endcase
  end

  // Counters, grant bookkeeping, captured byte and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_r     <= {CW{1'b0}};
      gap_cnt_r     <= {GW{1'b0}};
      burst_cnt_r   <= {BW{1'b0}};
      rr_ptr_r      <= {IDW{1'b0}};
      grant_id_r    <= {IDW{1'b0}};
      grant_vld_r   <= 1'b0;
      tx_byte_r     <= {BYTE_W{1'b0}};
      tx_start_r    <= 1'b0;
      last_flag_r   <= 1'b0;
      err_timeout_r <= 1'b0;
      busy_r        <= 1'b1;
      tx_done_q_r   <= 1'b0;
    end else begin
      tx_done_q_r <= bus.tx_done;
      tx_start_r  <= (state_nxt_s == START);
      busy_r      <= (state_nxt_s != IDLE);
      case (state_r)
        FLUSH: begin
          if (cyc_end_s) cyc_cnt_r <= {CW{1'b0}};
          else if (cyc_cnt_r != CYC_MAX) cyc_cnt_r <= cyc_cnt_r + CW'(1'b1);
        end
        IDLE: begin
          if (arb_any_s) begin
            grant_id_r  <= arb_idx_s;
            grant_vld_r <= 1'b1;
            burst_cnt_r <= {BW{1'b0}};
          end
        end
        LOAD: begin
          if (sel_valid_s) begin
            tx_byte_r   <= bus.req_data[{grant_id_r, 3'b000} +: BYTE_W];
            last_flag_r <= bus.req_last[grant_id_r];
            if (burst_cnt_r != BURST_MAX) burst_cnt_r <= burst_cnt_r + BW'(1'b1);
          end else begin
            grant_vld_r <= 1'b0;
            rr_ptr_r    <= rr_next_s;
          end
        end
        START: begin
          cyc_cnt_r <= {CW{1'b0}};
        end
        WAIT: begin
          if (done_rise_s) begin
            gap_cnt_r <= {GW{1'b0}};
          end else if (cyc_end_s) begin
            err_timeout_r <= 1'b1;
            gap_cnt_r     <= {GW{1'b0}};
          end else if (cyc_cnt_r != CYC_MAX) begin
            cyc_cnt_r <= cyc_cnt_r + CW'(1'b1);
          end
        end
        GAP: begin
          if (gap_end_s) begin
            if (!keep_lock_s) begin
              grant_vld_r <= 1'b0;
              rr_ptr_r    <= rr_next_s;
            end
          end else if (gap_cnt_r != GAP_MAX) begin
            gap_cnt_r <= gap_cnt_r + GW'(1'b1);
          end
        end
        default: begin
          cyc_cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter: a requester driver and a
// transmitter model surround the DUT; expected frames are queued by the
// stimulus and checked as each tx_start appears.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();
  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus_b ();

  logic       gv, busy, err;
  logic [1:0] gid;
  logic       gv_b, busy_b, err_b;
  logic [1:0] gid_b;

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(2), .MAX_BURST(16), .FRAME_CYCLES(1042)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .grant_vld(gv), .grant_id(gid), .busy(busy), .err_timeout(err)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(2), .MAX_BURST(2), .FRAME_CYCLES(1042)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .grant_vld(gv_b), .grant_id(gid_b), .busy(busy_b), .err_timeout(err_b)
  );

  typedef struct {
    logic [7:0] b;
    int         id;
    int         gap;
  } exp_t;

  typedef struct {
    int         id;
    logic [7:0] b;
  } got_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];
  got_t        got_b[$];
  logic [8:0]  rq[NR][$];
  logic [NR-1:0] took = '0;
  bit          model_en = 1'b1;
  int          tx_cnt = 0;
  int          tx_cnt_b = 0;
  int          cyc = 0;
  int          last_start = 0;
  int          rdy_cnt = 0;
  exp_t        mon_e;
  got_t        mon_g;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] b, input int id, input int gap);
    exp_t e;
    e.b = b; e.id = id; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < NR; i++) s += rq[i].size();
    return s;
  endfunction

  // Requesters: present queue heads, pop one cycle after a ready was seen.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (took[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      took[i] = bus.req_ready[i];
      if (rq[i].size() > 0) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = rq[i][0][7:0];
        bus.req_last[i]        = rq[i][0][8];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i]        = 1'b0;
      end
    end
  end

  // Transmitter models: done pulses high for two cycles, 18 cycles after start.
  always @(negedge clk) begin
    if (bus.tx_start && model_en) tx_cnt = 20;
    else if (tx_cnt > 0) tx_cnt--;
    bus.tx_done = (tx_cnt == 1 || tx_cnt == 2);
    if (bus_b.tx_start) tx_cnt_b = 20;
    else if (tx_cnt_b > 0) tx_cnt_b--;
    bus_b.tx_done = (tx_cnt_b == 1 || tx_cnt_b == 2);
  end

  // Scoreboard monitor on every start pulse.
  always @(negedge clk) begin
    cyc++;
    if (rst) rdy_cnt = 0;
    else rdy_cnt += $countones(bus.req_ready);
    if (bus.tx_start) begin
      check("start_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("tx_byte", 32'(bus.tx_byte), 32'(mon_e.b));
        check("grant_id", 32'(gid), mon_e.id);
        check("ready_per_frame", rdy_cnt, 32'd1);
        if (mon_e.gap != 0) check("start_spacing", cyc - last_start, mon_e.gap);
      end
      rdy_cnt = 0;
      last_start = cyc;
    end
    if (bus_b.tx_start) begin
      mon_g.id = int'(gid_b);
      mon_g.b  = bus_b.tx_byte;
      got_b.push_back(mon_g);
    end
  end

  task automatic do_reset();
    int n;
    logic [NR-1:0] rdy_or;
    logic start_seen;
    rst = 1'b1;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_grant_vld", 32'(gv), 32'd0);
    check("rst_grant_id", 32'(gid), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_byte", 32'(bus.tx_byte), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    n = 0;
    rdy_or = '0;
    start_seen = 1'b0;
    while (busy && n < 3000) begin
      n++;
      rdy_or |= bus.req_ready;
      start_seen |= bus.tx_start;
      step();
    end
    check("flush_len", n, 32'd1042);
    check("flush_ready", 32'(rdy_or), 32'd0);
    check("flush_start", 32'(start_seen), 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || pending() != 0 || busy) && n < budget) begin
      n++;
      step();
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n;
    n = 0;
    while (!bus.tx_start && n < budget) begin
      n++;
      step();
    end
    check(tag, 32'(bus.tx_start), 32'd1);
  endtask

  // Global time limit so a stuck run still terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    time t0;
    int  n;
    bus_b.req_valid = '0;
    bus_b.req_data  = '0;
    bus_b.req_last  = '0;

    // Reset, flush with no requests.
    do_reset();
    check("idle_grant_vld", 32'(gv), 32'd0);

    // Single byte from requester 2.
    rq[2].push_back({1'b1, 8'hA5});
    push_exp(8'hA5, 2, 0);
    n = 0;
    while (!bus.req_valid[2] && n < 10) begin n++; step(); end
    t0 = $time;
    step();
    check("single_ready", 32'(bus.req_ready), 32'h4);
    check("single_grant_vld", 32'(gv), 32'd1);
    step();
    check("single_latency", int'(($time - t0) / 10), 32'd2);
    check("single_start", 32'(bus.tx_start), 32'd1);
    step();
    check("start_one_cycle", 32'(bus.tx_start), 32'd0);
    n = 0;
    while (!bus.tx_done && n < 50) begin n++; step(); end
    step();
    step();
    check("gap_holds_grant", 32'(gv), 32'd1);
    step();
    check("single_release", 32'(gv), 32'd0);
    check("single_rr_ptr", 32'(dut.rr_ptr_r), 32'd3);
    check("single_idle", 32'(busy), 32'd0);

    // Reset during WAIT restarts the flush.
    model_en = 1'b0;
    rq[1].push_back({1'b1, 8'h5A});
    push_exp(8'h5A, 1, 0);
    wait_start("midwait_start", 20);
    repeat (10) step();
    check("midwait_busy", 32'(busy), 32'd1);
    check("midwait_grant", 32'(gv), 32'd1);
    do_reset();
    model_en = 1'b1;

    // Round robin 0,1,3,0 from pointer 0.
    rq[0].push_back({1'b1, 8'h01});
    rq[0].push_back({1'b1, 8'h02});
    rq[1].push_back({1'b1, 8'h11});
    rq[3].push_back({1'b1, 8'h31});
    push_exp(8'h01, 0, 0);
    push_exp(8'h11, 1, 23);
    push_exp(8'h31, 3, 23);
    push_exp(8'h02, 0, 23);
    wait_idle("rr_drain", 500);

    // Burst lock: requester 1 sends three bytes while 0 waits.
    rq[1].push_back({1'b0, 8'hB1});
    rq[1].push_back({1'b0, 8'hB2});
    rq[1].push_back({1'b1, 8'hB3});
    rq[0].push_back({1'b1, 8'h0C});
    push_exp(8'hB1, 1, 0);
    push_exp(8'hB2, 1, 22);
    push_exp(8'hB3, 1, 22);
    push_exp(8'h0C, 0, 23);
    wait_idle("burst_drain", 500);
    check("burst_no_err", 32'(err), 32'd0);

    // Watchdog: tx_done never arrives.
    model_en = 1'b0;
    rq[3].push_back({1'b1, 8'h3C});
    push_exp(8'h3C, 3, 0);
    wait_start("timeout_start", 20);
    t0 = $time;
    n = 0;
    while (!err && n < 1500) begin n++; step(); end
    check("timeout_delay", int'(($time - t0) / 10), 32'd1043);
    model_en = 1'b1;
    wait_idle("timeout_release", 50);
    rq[2].push_back({1'b1, 8'h77});
    push_exp(8'h77, 2, 0);
    wait_idle("after_timeout_drain", 200);
    check("err_sticky", 32'(err), 32'd1);

    // Burst limit of 2 on the second instance.
    bus_b.req_data  = {8'h00, 8'h00, 8'h21, 8'h10};
    bus_b.req_last  = 4'b0010;
    bus_b.req_valid = 4'b0011;
    n = 0;
    while (got_b.size() < 3 && n < 300) begin n++; step(); end
    bus_b.req_valid = 4'b0000;
    check("limit_frames", 32'(got_b.size() >= 3), 32'd1);
    if (got_b.size() >= 3) begin
      check("limit_id0", got_b[0].id, 32'd0);
      check("limit_id1", got_b[1].id, 32'd0);
      check("limit_id2", got_b[2].id, 32'd1);
      check("limit_byte0", 32'(got_b[0].b), 32'h10);
      check("limit_byte2", 32'(got_b[2].b), 32'h21);
    end
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
